// File: rtl/md_pkg.sv
// Shared multiply/divide op encodings and FSM state constants, also imported by the CPU decoder.
// Combinational only; no latency or flow control of its own.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef logic [0:0] md_state_t;
  localparam md_state_t MD_IDLE = 1'b0;
  localparam md_state_t MD_RUN  = 1'b1;

  function automatic int md_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_div.sv
// Combinational signed/unsigned divider with divide-by-zero and signed-overflow rules (built only with MD_UNIT_DIV_EN).
// Zero latency; no flow control, the caller holds operands stable for the op's duration.
module md_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_uquo;
  logic [WIDTH-1:0] w_urem;

  assign w_neg_a = i_signed & i_a[WIDTH-1];
  assign w_neg_b = i_signed & i_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;
  assign w_uquo  = w_mag_a / w_mag_b;
  assign w_urem  = w_mag_a % w_mag_b;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    o_quo = w_uquo;
    o_rem = w_urem;
    if (i_b == '0) begin
      o_quo = '1;
      o_rem = i_a;
    end else if (i_signed && (i_a == MOST_NEG) && (i_b == '1)) begin
      o_quo = i_a;
      o_rem = '0;
    end else begin
      if (w_neg_a ^ w_neg_b) o_quo = -w_uquo;
      if (w_neg_a)           o_rem = -w_urem;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; divide is present only when MD_UNIT_DIV_EN is defined.
// MUL_CYCLES/DIV_CYCLES latency with busy held throughout; start while busy is dropped, flush cancels without writing.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(md_max(MUL_CYCLES, DIV_CYCLES) + 1);

  md_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_take;
  logic [CNT_W-1:0]   w_lat;
  logic [2*WIDTH-1:0] w_smul;
  logic [2*WIDTH-1:0] w_umul;
  logic [2*WIDTH-1:0] w_res;

  assign w_is_mul = (op == MD_MULT) || (op == MD_MULTU);
  assign w_take   = start && !flush;

  // Operands extended to full product width so the low 2*WIDTH bits are exact.
  assign w_smul = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_umul = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

`ifdef MD_UNIT_DIV_EN
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign w_lat    = w_is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);

  md_div #(.WIDTH(WIDTH)) u_div (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_signed (r_op == MD_DIV),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );
`else
  assign w_is_div = 1'b0;
  assign w_lat    = CNT_W'(MUL_CYCLES);
`endif

  always_comb begin
    w_res = w_smul;
    case (r_op)
      MD_MULTU: w_res = w_umul;
`ifdef MD_UNIT_DIV_EN
      MD_DIV,
      MD_DIVU:  w_res = {w_rem, w_quo};
`endif
      default:  w_res = w_smul;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_take) begin
            if (w_is_mul || w_is_div) begin
              r_a     <= A;
              r_b     <= B;
              r_op    <= op;
              r_cnt   <= w_lat;
              r_state <= MD_RUN;
            end else if (op == MD_MTHI) begin
              hi <= A;
            end else if (op == MD_MTLO) begin
              lo <= A;
            end
          end
        end
        MD_RUN: begin
          // Flush beats completion on the same edge.
          if (flush) begin
            r_cnt   <= '0;
            r_state <= MD_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              hi      <= w_res[2*WIDTH-1:WIDTH];
              lo      <= w_res[WIDTH-1:0];
              r_state <= MD_IDLE;
            end
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (r_state == MD_RUN);

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; divide expectations follow MD_UNIT_DIV_EN.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .A       (a_in),
    .B       (b_in),
    .flush   (flush),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One start pulse, sampled on the next rising edge; returns 1ns after that edge.
  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic f);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b; flush = f;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic busy0, output int cycles);
    pulse(o, a, b, 1'b0);
    busy0 = busy;
    cycles = 0;
    if (busy0) begin
      while (busy && cycles < 200) begin
        @(posedge clk);
        #1;
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; op = 3'b000; a_in = '0; b_in = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_mult();
    logic b0; int n;
    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, b0, n);
    checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL mult_busy0 got=%0h exp=1", b0); end
    checks++; if (n != 5) begin failures++; $display("FAIL mult_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_multu();
    logic b0; int n;
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, b0, n);
    checks++; if (n != 5) begin failures++; $display("FAIL multu_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
  endtask

  task automatic test_div();
    logic b0; int n;
`ifdef MD_UNIT_DIV_EN
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, b0, n);
    checks++; if (n != 10) begin failures++; $display("FAIL div_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    run_op(MD_DIVU, 32'd7, 32'd0, b0, n);
    checks++; if (n != 10) begin failures++; $display("FAIL divu0_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo); end
    checks++; if (hi !== 32'h00000007) begin failures++; $display("FAIL divu0_hi got=%h exp=00000007", hi); end
`else
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, b0, n);
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL div_off_busy got=%0h exp=0", b0); end
    run_op(MD_DIVU, 32'd7, 32'd0, b0, n);
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL divu_off_busy got=%0h exp=0", b0); end
    checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL div_off_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL div_off_lo got=%h exp=fffffffe", lo); end
`endif
  endtask

  // Without the divider the same operands through MULT give the same HI/LO.
  task automatic test_overflow_ignore();
    int n;
`ifdef MD_UNIT_DIV_EN
    logic [2:0] o = MD_DIV;
    int exp_n = 10;
`else
    logic [2:0] o = MD_MULT;
    int exp_n = 5;
`endif
    pulse(MD_MTHI, 32'h77, 32'h0, 1'b0);
    checks++; if (hi !== 32'h77) begin failures++; $display("FAIL mthi_hi got=%h exp=00000077", hi); end
    pulse(o, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    @(posedge clk);
    #1;
    pulse(MD_MTHI, 32'h55, 32'h0, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%0h exp=1", busy); end
    checks++; if (hi !== 32'h77) begin failures++; $display("FAIL ign_hi got=%h exp=00000077", hi); end
    n = 2;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n != exp_n) begin failures++; $display("FAIL ovf_cycles got=%0d exp=%0d", n, exp_n); end
    checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL ovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_flush();
    pulse(MD_MTHI, 32'hCAFE, 32'h0, 1'b0);
    pulse(MD_MTLO, 32'h1234, 32'h0, 1'b0);
    checks++; if (lo !== 32'h1234) begin failures++; $display("FAIL mtlo_lo got=%h exp=00001234", lo); end
    checks++; if (hi !== 32'hCAFE) begin failures++; $display("FAIL mtlo_hi got=%h exp=0000cafe", hi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%0h exp=0", busy); end
    pulse(MD_MULT, 32'd3, 32'd4, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%0h exp=0", busy); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (lo !== 32'h1234) begin failures++; $display("FAIL flush_lo got=%h exp=00001234", lo); end
    checks++; if (hi !== 32'hCAFE) begin failures++; $display("FAIL flush_hi got=%h exp=0000cafe", hi); end
    pulse(MD_MTHI, 32'h55, 32'h0, 1'b1);
    checks++; if (hi !== 32'hCAFE) begin failures++; $display("FAIL idle_flush_mthi got=%h exp=0000cafe", hi); end
    pulse(MD_MULT, 32'd3, 32'd4, 1'b1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_flush_mult got=%0h exp=0", busy); end
  endtask

  task automatic test_flush_final();
    pulse(MD_MULT, 32'd3, 32'd4, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL final_flush_busy got=%0h exp=0", busy); end
    checks++; if (lo !== 32'h1234) begin failures++; $display("FAIL final_flush_lo got=%h exp=00001234", lo); end
    checks++; if (hi !== 32'hCAFE) begin failures++; $display("FAIL final_flush_hi got=%h exp=0000cafe", hi); end
  endtask

  task automatic test_noop();
    pulse(3'b110, 32'hDEAD, 32'h1, 1'b0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noop6_busy got=%0h exp=0", busy); end
    pulse(3'b111, 32'hBEEF, 32'h1, 1'b0);
    checks++; if (hi !== 32'hCAFE) begin failures++; $display("FAIL noop_hi got=%h exp=0000cafe", hi); end
    checks++; if (lo !== 32'h1234) begin failures++; $display("FAIL noop_lo got=%h exp=00001234", lo); end
  endtask

  task automatic test_back_to_back();
    logic b0; int n;
    run_op(MD_MULT, 32'd5, 32'd6, b0, n);
    checks++; if (n != 5) begin failures++; $display("FAIL b2b1_cycles got=%0d exp=5", n); end
    checks++; if (lo !== 32'd30) begin failures++; $display("FAIL b2b1_lo got=%h exp=0000001e", lo); end
    run_op(MD_MULTU, 32'h10000, 32'h10000, b0, n);
    checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL b2b2_busy0 got=%0h exp=1", b0); end
    checks++; if (n != 5) begin failures++; $display("FAIL b2b2_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'h1) begin failures++; $display("FAIL b2b2_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL b2b2_lo got=%h exp=0", lo); end
  endtask

  task automatic test_async_reset();
    pulse(MD_MTHI, 32'hABCD, 32'h0, 1'b0);
    pulse(MD_MTLO, 32'h5678, 32'h0, 1'b0);
    pulse(MD_MULT, 32'd2, 32'd2, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0h exp=0", busy); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL arst_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL arst_lo got=%h exp=0", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_resume got=%0h exp=0", busy); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_overflow_ignore();
    test_flush();
    test_flush_final();
    test_noop();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the EX stage of the pipelined CPU. It accepts one operation per start pulse and holds `busy` for a fixed, configurable latency, during which the stall logic freezes the pipeline. It adds signed/unsigned multiply and divide, HI/LO moves, and flush, none of which the single-cycle ALU has.

## Interface
- `WIDTH`, 32: operand, HI and LO width (≥ 8).
- `MUL_CYCLES`, 5: multiply latency in cycles (≥ 1).
- `DIV_CYCLES`, 10: divide latency in cycles (≥ 1).

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: operation request, sampled on rising edges.
- `op` input 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x is a no-op.
- `A` input WIDTH: rs operand.
- `B` input WIDTH: rt operand.
- `flush` input 1: cancels the in-flight operation (exception or branch kill).
- `busy` output 1: operation in flight.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States are IDLE and RUN.
- In IDLE with `start`=1:
  - MULT/MULTU/DIV/DIVU: latch A, B and op; load the counter with the op latency; go to RUN.
  - MTHI: `hi`←A on that edge; LO unchanged; stay IDLE; `busy` stays 0.
  - MTLO: `lo`←A on that edge; HI unchanged; stay IDLE; `busy` stays 0.
  - `op` 11x: nothing happens.
- In RUN:
  - The counter decrements each edge.
  - On the edge where the counter reaches 0, HI/LO are written from the latched result and the state returns to IDLE.
- `start` while in RUN is ignored; no queueing. The pipeline must not issue while `busy`.
- `flush` in RUN: return to IDLE on that edge; HI/LO unchanged.
- `flush` in IDLE: suppresses a simultaneous `start`, including MTHI/MTLO.
- Multiply results:
  - MULT: {hi,lo} = signed A × signed B, full 2·WIDTH result.
  - MULTU: {hi,lo} = unsigned A × unsigned B.
- Divide results:
  - DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B=0), both DIV and DIVU: lo = all ones, hi = A.
- Signed overflow (DIV with A = most-negative, B = −1): lo = A, hi = 0.
- `hi`/`lo` are directly registered outputs. `busy` is the state decode (RUN), registered.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Asserting `reset_n`=0 mid-operation aborts immediately (asynchronously). HI/LO are cleared.
- MUL/DIV with `start` sampled at edge 0:
  - `busy`=1 after edge 0.
  - `busy` stays high for exactly N cycles, where N is `MUL_CYCLES` or `DIV_CYCLES`.
  - At edge N, `hi`/`lo` update and `busy` falls together.
  - A new `start` is accepted at edge N+1 at the earliest.
- MTHI/MTLO: single cycle; the new value is visible after the sampling edge.
- `flush` and the final RUN edge coinciding: `flush` wins; no write.

## Configuration
- `MD_UNIT_DIV_EN`:
  - Defined: DIV/DIVU are implemented as above.
  - Undefined: the divider logic is omitted. DIV/DIVU behave as no-ops: no `busy`, HI/LO unchanged. `DIV_CYCLES` is ignored.

## Structure
- Shared package `md_pkg`:
  - Op encoding constants `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`.
  - State typedef (IDLE/RUN).
  - The CPU decoder imports the same op constants.
- One sub-module, `md_div`:
  - Combinational signed/unsigned divide.
  - Owns the divide-by-zero and overflow rules.
  - Instantiated only under `MD_UNIT_DIV_EN`.
- Counter width is `$clog2(max(MUL_CYCLES, DIV_CYCLES)+1)`.

## Test plan
- Reset, then MULT with A=0xFFFFFFFE, B=3: `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFF, B=2: hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV with A=−7, B=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. Then DIVU with A=7, B=0: lo=0xFFFFFFFF, hi=7.
- DIV with A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0. A second `start` (MTHI 0x55) while busy is ignored, so hi stays 0.
- MTLO A=0x1234, then MULT, with `flush` asserted on the 3rd busy cycle: `busy` drops on that edge, lo stays 0x1234, hi stays unchanged.
- MULT in flight, then `reset_n` pulsed low mid-cycle: `busy`, `hi` and `lo` go to 0 without waiting for a clock edge.
